// File: rtl/fetch_pc_gen.sv
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : Fetch PC owner, I-cache read port driver and fetch sideband.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        interlock,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  output logic [31:0] PC_F,
  output logic [31:0] PC_4_F,
  output logic        PC_sel_F,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_target;
  logic [31:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_nxt;
  logic        w_cnt_inc;
  logic        w_re;
  logic        w_sel;
  logic [31:0] w_target;
  logic [31:0] w_pc_out;

  assign w_target = redirect_target & ~32'h0000_0003;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_target;
    w_cnt_inc   = 1'b0;
    w_re        = 1'b0;
    w_sel       = 1'b1;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        w_re = 1'b1;
        if (stall && redirect_valid) begin
          w_pend_nxt  = w_target;
          w_state_nxt = PEND;
        end else if (stall) begin
          w_sel = 1'b0;
        end else if (redirect_valid) begin
          w_pc_nxt = w_target;
        end else if (interlock) begin
          w_sel = 1'b0;
        end else begin
          w_pc_nxt  = r_pc + 32'd4;
          w_sel     = 1'b0;
          w_cnt_inc = 1'b1;
        end
      end
      PEND: begin
        w_re = 1'b1;
        if (stall) begin
          if (redirect_valid) w_pend_nxt = w_target;
        end else begin
          // A redirect in the release cycle is newer than the buffered one.
          w_pc_nxt    = redirect_valid ? w_target : r_pend_target;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_pend_target <= 32'h0;
      r_fetch_count <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend_target <= w_pend_nxt;
      if (w_cnt_inc) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // Reset forces the boot-time view even before the first reset edge lands.
  assign w_pc_out    = reset ? RESET_PC : r_pc;
  assign icache_addr = w_pc_out;
  assign PC_F        = w_pc_out;
  assign PC_4_F      = w_pc_out + 32'd4;
  assign icache_re   = reset ? 1'b0 : w_re;
  assign PC_sel_F    = reset ? 1'b1 : w_sel;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Instruction-fetch front end of the pipeline: owns the fetch PC, drives the instruction-cache read port, and produces the fetch-stage sideband (PC+4, squash flag) consumed by the fetch/decode pipeline register. Redirect, interlock and stall requests from downstream stages steer the next-PC selection. Redirects arriving during a stall are buffered and applied when the stall drops. A retired-fetch counter supports performance monitoring.

## Interface
- `RESET_PC`, default `32'h4000_0000`: fetch address after reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: global pipeline stall; fetch state frozen.
- `interlock` in 1: decode hazard; re-fetch the current PC.
- `redirect_valid` in 1: taken branch or jump resolved downstream.
- `redirect_target` in 32: redirect address; bits [1:0] ignored and forced to 0.
- `icache_addr` out 32: read address presented to the instruction cache this cycle; data returns next cycle.
- `icache_re` out 1: cache read enable.
- `PC_F` out 32: address of the instruction being fetched this cycle (equals `icache_addr`).
- `PC_4_F` out 32: `PC_F + 4`, modulo 2^32.
- `PC_sel_F` out 1: high marks the instruction fetched this cycle as squashed; downstream replaces it with a bubble.
- `fetch_count` out 32: count of committed, non-squashed fetches.

## Operation
- Registers:
  - `pc` (32).
  - `state` ∈ {BOOT, RUN, PEND}.
  - `pend_target` (32).
  - `fetch_count` (32).
- Reset values:
  - `pc` = `RESET_PC`; `state` = BOOT; `pend_target` = 0; `fetch_count` = 0.
  - Outputs during reset: `icache_re` = 0, `PC_sel_F` = 1, `icache_addr` = `PC_F` = `RESET_PC`, `PC_4_F` = `RESET_PC + 4`.
- All outputs are combinational from the registers and inputs. `icache_addr` = `PC_F` = `pc`; `PC_4_F` = `pc + 4`.
- BOOT:
  - `icache_re` = 0, `PC_sel_F` = 1.
  - `pc` is held; `stall`, `interlock` and redirect inputs are ignored.
  - Next state is always RUN.
- RUN, `icache_re` = 1. Priority order, first match wins:
  - `stall` & `redirect_valid`: `pc` held; `pend_target` <= target & ~3; go to PEND; `PC_sel_F` = 1.
  - `stall`: `pc` held; `PC_sel_F` = 0; count held.
  - `redirect_valid`: `pc` <= target & ~3; `PC_sel_F` = 1; count held.
  - `interlock`: `pc` held (same address re-read); `PC_sel_F` = 0; count held.
  - Otherwise: `pc` <= `pc + 4`; `PC_sel_F` = 0; `fetch_count` += 1.
- PEND: `icache_re` = 1, `PC_sel_F` = 1.
  - `stall` & `redirect_valid`: `pend_target` is overwritten (the newest redirect wins).
  - `stall` alone: hold.
  - `!stall`: `pc` <= (`redirect_valid` ? target & ~3 : `pend_target`); go to RUN; count held.
  - `interlock` is ignored in PEND.
- `fetch_count` wraps from `32'hFFFF_FFFF` to 0.
- `reset` asserted in any state overrides everything and returns the block to BOOT with the reset values.

## Timing
- Next-PC latency: a redirect sampled at edge N (not stalled) puts the target on `icache_addr` in cycle N+1.
- The cache returns data for `icache_addr` one cycle later. `PC_sel_F` is aligned with the cycle in which the address is presented.
- BOOT lasts exactly one cycle after `reset` deasserts. The first real fetch of `RESET_PC` occurs in the second cycle after reset release.
- Stall hold: `icache_addr` stays constant for every stalled cycle, and `icache_re` stays 1 (except in BOOT).
- PEND always leaves at least one squashed fetch. The PC held at stall entry is discarded.
- No combinational path from `icache_*` back into the block. The paths from `stall`, `interlock` and `redirect_*` to `PC_sel_F` are combinational.

## Test plan
- Reset/boot: hold `reset` for 3 cycles, then release.
  - Release cycle: `icache_re` = 0, `PC_sel_F` = 1, `icache_addr` = `32'h4000_0000`.
  - Next cycle: `icache_re` = 1, `PC_sel_F` = 0.
  - Following cycle: `icache_addr` = `32'h4000_0004`.
- Sequential fetch plus redirect:
  - 4 free-running cycles give addresses x000, x004, x008, x00C.
  - Then `redirect_valid` = 1 with target `32'h1000_0023`: that cycle `PC_sel_F` = 1; next `icache_addr` = `32'h1000_0020`.
  - `fetch_count` = 4.
- Interlock: assert `interlock` for 2 cycles at `pc` = `32'h4000_0010`.
  - `icache_addr` stays `32'h4000_0010` for 3 cycles, then becomes `32'h4000_0014`.
  - `PC_sel_F` stays 0 throughout.
- Redirect during stall:
  - `stall` high for 4 cycles, with redirect to `32'h2000_0000` in stall cycle 1 and to `32'h3000_0000` in stall cycle 3.
  - `icache_addr` is held for all 4 cycles and `PC_sel_F` = 1 in stall cycles 1-4.
  - After the stall drops, `icache_addr` = `32'h3000_0000`.
- Reset mid-PEND: enter PEND, then assert `reset`.
  - Next cycle: BOOT, `pc` = `RESET_PC`, `fetch_count` = 0.
  - The pending target is never fetched.
- Counter wrap: preload by running with `fetch_count` forced to `32'hFFFF_FFFE`, then do 2 free fetches; `fetch_count` reads `32'h0000_0000`.
